// File: rtl/bitserial_incrementer.sv
// Bit-serial conditional incrementer: streams a word LSB-first through one half adder,
// carrying between bit steps, with valid/ready handshakes on both sides.

module adder_1bit_half #(
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic cout_o
);

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  if (IMPL_TYPE == 0) begin : g_xor_and
    assign sum_o  = a_i ^ b_i;
    assign cout_o = a_i & b_i;
  end else if (IMPL_TYPE == 1) begin : g_maj_not
    // maj(a,b,0) = a&b; maj(~c, a|b, 0) = (a|b) & ~(a&b) = a^b
    assign cout_o = maj(a_i, b_i, 1'b0);
    assign sum_o  = maj(~cout_o, maj(a_i, b_i, 1'b1), 1'b0);
  end else begin : g_bad_impl
    $error("adder_1bit_half: unsupported IMPL_TYPE");
  end

endmodule

module bitserial_incrementer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  op_sr_q, op_sr_d;
  logic [WIDTH-1:0]  res_sr_q, res_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_cout_q, out_cout_d;

  logic              ha_sum, ha_cout;
  logic [WIDTH-1:0]  res_shift;
  logic              last_bit;

  adder_1bit_half #(
    .IMPL_TYPE(IMPL_TYPE)
  ) u_ha (
    .a_i   (op_sr_q[0]),
    .b_i   (carry_q),
    .sum_o (ha_sum),
    .cout_o(ha_cout)
  );

  assign last_bit = (bit_cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    res_shift            = res_sr_q >> 1;
    res_shift[WIDTH-1]   = ha_sum;
  end

  always_comb begin
    state_d    = state_q;
    op_sr_d    = op_sr_q;
    res_sr_d   = res_sr_q;
    carry_d    = carry_q;
    bit_cnt_d  = bit_cnt_q;
    out_data_d = out_data_q;
    out_cout_d = out_cout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_sr_d   = in_data;
          carry_d   = in_cin;
          res_sr_d  = '0;
          bit_cnt_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        res_sr_d  = res_shift;
        op_sr_d   = op_sr_q >> 1;
        carry_d   = ha_cout;
        bit_cnt_d = bit_cnt_q + CntW'(1);
        if (last_bit) begin
          state_d    = StDone;
          out_data_d = res_shift;
          out_cout_d = ha_cout;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_sr_q    <= '0;
      res_sr_q   <= '0;
      carry_q    <= 1'b0;
      bit_cnt_q  <= '0;
      out_data_q <= '0;
      out_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_sr_q    <= op_sr_d;
      res_sr_q   <= res_sr_d;
      carry_q    <= carry_d;
      bit_cnt_q  <= bit_cnt_d;
      out_data_q <= out_data_d;
      out_cout_q <= out_cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_bitserial_incrementer.sv
// Bench for bitserial_incrementer: directed, exhaustive and randomized traffic against an
// arithmetic model (result = operand + cin, split into data and carry-out).

module tb_bitserial_incrementer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two 8-bit DUTs (one per adder implementation) share the same stimulus.
  logic       in_valid, in_cin, out_ready;
  logic [7:0] in_data;
  logic       a_in_ready, a_out_valid, a_out_cout, a_busy;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_cout, b_busy;
  logic [7:0] b_out_data;

  logic       w_in_valid, w_in_cin, w_out_ready;
  logic [0:0] w_in_data;
  logic       w_in_ready, w_out_valid, w_out_cout, w_busy;
  logic [0:0] w_out_data;

  bitserial_incrementer #(.WIDTH(8), .IMPL_TYPE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_cin(in_cin), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_cout(a_out_cout), .busy(a_busy)
  );

  bitserial_incrementer #(.WIDTH(8), .IMPL_TYPE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_cin(in_cin), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_cout(b_out_cout), .busy(b_busy)
  );

  bitserial_incrementer #(.WIDTH(1), .IMPL_TYPE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_cin(w_in_cin), .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_cout(w_out_cout), .busy(w_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset8(input string tag);
    chk({tag, "_a_rdy"}, 32'(a_in_ready), 1);
    chk({tag, "_a_vld"}, 32'(a_out_valid), 0);
    chk({tag, "_a_busy"}, 32'(a_busy), 0);
    chk({tag, "_a_res"}, {23'd0, a_out_cout, a_out_data}, 0);
    chk({tag, "_b_rdy"}, 32'(b_in_ready), 1);
    chk({tag, "_b_vld"}, 32'(b_out_valid), 0);
    chk({tag, "_b_res"}, {23'd0, b_out_cout, b_out_data}, 0);
  endtask

  // Wait (bounded) for out_valid on the 8-bit pair, then compare both results.
  task automatic wait_result8(input string tag, input logic [8:0] exp, output int lat);
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      chk({tag, "_busy"}, 32'(a_busy & b_busy), 1);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_a_vld"}, 32'(a_out_valid), 1);
    chk({tag, "_b_vld"}, 32'(b_out_valid), 1);
    chk({tag, "_a_res"}, {23'd0, a_out_cout, a_out_data}, 32'(exp));
    chk({tag, "_b_res"}, {23'd0, b_out_cout, b_out_data}, 32'(exp));
  endtask

  // Entered at a negedge in IDLE; returns at the negedge where out_valid is first seen.
  task automatic xfer8(input logic [7:0] d, input logic c, input string tag);
    logic [8:0] exp;
    int lat;
    exp = {1'b0, d} + 9'(c);
    chk({tag, "_in_rdy"}, 32'(a_in_ready & b_in_ready), 1);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_cin   = 1'($urandom);
    wait_result8(tag, exp, lat);
    chk({tag, "_lat"}, 32'(lat), 8);
  endtask

  logic [8:0] q[$];
  logic [8:0] e9;
  logic [1:0] e2;
  logic [7:0] held;
  int lat, k, t, prev, acc;
  bit seen;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_cin = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_cin = 1'b0; w_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk_reset8("reset");
    chk("reset_w_rdy", 32'(w_in_ready), 1);
    chk("reset_w_res", {30'd0, w_out_cout, w_out_data}, 0);

    // Basic, wrap-around, pass-through.
    xfer8(8'h3A, 1'b1, "basic");
    @(negedge clk);
    chk("basic_rdy_back", 32'(a_in_ready), 1);
    xfer8(8'hFF, 1'b1, "wrap_ff");
    @(negedge clk);
    xfer8(8'h7F, 1'b1, "wrap_7f");
    @(negedge clk);
    xfer8(8'hA5, 1'b0, "pass_a5");
    @(negedge clk);

    // Backpressure: DONE held for 5 cycles with a word waiting upstream.
    out_ready = 1'b0;
    xfer8(8'h5C, 1'b1, "bp");
    in_valid = 1'b1; in_data = 8'h11; in_cin = 1'b0;
    held = a_out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(a_out_valid & b_out_valid), 1);
      chk("bp_data", 32'(a_out_data), 32'(held));
      chk("bp_in_rdy", 32'(a_in_ready | b_in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 32'(a_in_ready), 1);
    chk("bp_rel_vld", 32'(a_out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result8("bp_11", 9'h011, lat);
    chk("bp_11_lat", 32'(lat), 8);
    @(negedge clk);

    // Reset mid-run at bit_cnt == 3.
    in_valid = 1'b1; in_data = 8'h0F; in_cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset8("midrst");
    for (int i = 0; i < 12; i++) begin
      chk("midrst_no_vld", 32'(a_out_valid | b_out_valid), 0);
      @(negedge clk);
    end
    xfer8(8'h10, 1'b1, "after_rst");
    @(negedge clk);

    // Exhaustive back-to-back, both implementations.
    prev = 0;
    for (int i = 0; i < 512; i++) begin
      k = 0;
      while (!a_in_ready && k < 30) begin
        @(negedge clk);
        k++;
      end
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_cin   = 1'(i >> 8);
      e9 = {1'b0, in_data} + 9'(in_cin);
      @(negedge clk);
      t = cyc;
      if (i > 0) chk("exh_period", 32'(t - prev), 10);
      prev = t;
      wait_result8("exh", e9, lat);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // WIDTH = 1, all input combinations.
    for (int j = 0; j < 4; j++) begin
      chk("w1_rdy", 32'(w_in_ready), 1);
      w_in_valid = 1'b1;
      w_in_data  = 1'(j);
      w_in_cin   = 1'(j >> 1);
      e2 = {1'b0, w_in_data} + 2'(w_in_cin);
      @(negedge clk);
      w_in_valid = 1'b0;
      lat = 0;
      while (!w_out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk("w1_lat", 32'(lat), 1);
      chk("w1_res", {30'd0, w_out_cout, w_out_data}, 32'(e2));
      @(negedge clk);
    end

    // Randomized traffic with random backpressure and idle gaps.
    acc  = 0;
    seen = 1'b0;
    for (int n = 0; n < 3000 && (acc < 40 || q.size() > 0); n++) begin
      if (a_out_valid && !seen) begin
        chk("rnd_q_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("rnd_a", {23'd0, a_out_cout, a_out_data}, 32'(q[0]));
          chk("rnd_b", {23'd0, b_out_cout, b_out_data}, 32'(q[0]));
        end
        seen = 1'b1;
      end
      out_ready = ($urandom_range(2) != 0);
      if (a_out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        seen = 1'b0;
      end
      in_data = 8'($urandom);
      in_cin  = 1'($urandom);
      in_valid = (acc < 40) ? 1'($urandom) : 1'b0;
      if (a_in_ready && in_valid) begin
        q.push_back({1'b0, in_data} + 9'(in_cin));
        acc++;
      end
      @(negedge clk);
    end
    chk("rnd_accepted", 32'(acc), 40);
    chk("rnd_drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
